pcm_playback_pacer: RTL and testbench

Synthesizable, parametrised successor to the simulation-only codec playback model. It buffers multi-channel PCM frames from a producer through a small FIFO and releases exactly one frame per fixed frame period. Each release is marked with a one-cycle strobe, and underruns are flagged. It sits between the audio generator and the codec serialiser and replaces the free-running accept bit with a proper valid/ready front end.

---
 rtl/pcm_pkg.sv | 18 +
 rtl/pcm_sync_fifo.sv | 61 ++++++
 rtl/pcm_playback_pacer.sv | 105 ++++++++++
 tb/tb_pcm_playback_pacer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared constants, frame type and helpers for the PCM playback pacer.
package pcm_pkg;

  localparam int PCM_CHANNELS       = 2;
  localparam int PCM_SAMPLE_W       = 16;
  localparam int PCM_FRAME_PERIOD   = 32;
  localparam int PCM_UNDERRUN_CNT_W = 16;

  // Channel 0 (left) occupies the least significant sample slot.
  typedef logic [PCM_CHANNELS-1:0][PCM_SAMPLE_W-1:0] pcm_frame_t;

  function automatic logic [PCM_UNDERRUN_CNT_W-1:0] pcm_sat_inc(
    input logic [PCM_UNDERRUN_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock frame FIFO with an explicit fill counter; push is ignored when
// full and pop is ignored when empty.
module pcm_sync_fifo
  import pcm_pkg::*;
#(
  parameter int WIDTH = PCM_CHANNELS * PCM_SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              do_push, do_pop;

  assign full_o  = (fill_q == FULL_LVL);
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full/empty come from registered fill, so a pop never frees space this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q + FILL_W'(do_push) - FILL_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pcm_playback_pacer.sv
// Releases one buffered PCM frame per FRAME_PERIOD cycles with strobe and
// underrun flags. Optional tally: define PCM_PACER_UNDERRUN_CNT_EN.
module pcm_playback_pacer
  import pcm_pkg::*;
#(
  parameter int CHANNELS     = PCM_CHANNELS,
  parameter int SAMPLE_W     = PCM_SAMPLE_W,
  parameter int DEPTH        = 4,
  parameter int FRAME_PERIOD = PCM_FRAME_PERIOD
) (
  input  logic                          ClkIn,
  input  logic                          Reset_n,
  input  logic                          Enable,
  input  logic [CHANNELS*SAMPLE_W-1:0]  In_Data,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  output logic                          Frame_Strobe,
  output logic [CHANNELS*SAMPLE_W-1:0]  Out_Data,
  output logic                          Out_Valid,
  output logic                          Underrun,
  output logic [$clog2(DEPTH+1)-1:0]    Fill,
  output logic [PCM_UNDERRUN_CNT_W-1:0] Underrun_Count
);

  localparam int DATA_W = CHANNELS * SAMPLE_W;
  localparam int CNT_W  = $clog2(FRAME_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  pcm_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (ClkIn),
    .rst_ni  (Reset_n),
    .push_i  (In_Valid),
    .data_i  (In_Data),
    .pop_i   (strobe_q),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (Fill)
  );

  always_comb begin
    cnt_d       = '0;
    strobe_d    = Enable && (cnt_q == CNT_LAST);
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    underrun_d  = 1'b0;
    if (Enable && (cnt_q != CNT_LAST)) cnt_d = cnt_q + 1'b1;
    // The strobe pops the FIFO on the same edge that loads the output register.
    if (strobe_q) begin
      if (!fifo_empty) begin
        out_data_d  = fifo_head;
        out_valid_d = 1'b1;
      end else begin
        underrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge ClkIn or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign In_Ready     = !fifo_full;
  assign Frame_Strobe = strobe_q;
  assign Out_Data     = out_data_q;
  assign Out_Valid    = out_valid_q;
  assign Underrun     = underrun_q;

`ifdef PCM_PACER_UNDERRUN_CNT_EN
  logic [PCM_UNDERRUN_CNT_W-1:0] urun_cnt_q;

  always_ff @(posedge ClkIn or negedge Reset_n) begin
    if (!Reset_n)        urun_cnt_q <= '0;
    else if (underrun_q) urun_cnt_q <= pcm_sat_inc(urun_cnt_q);
  end

  assign Underrun_Count = urun_cnt_q;
`else
  assign Underrun_Count = '0;
`endif

endmodule

// File: tb/tb_pcm_playback_pacer.sv
// Scoreboard bench for pcm_playback_pacer: default instance plus a 4x24-bit,
// depth-8, period-5 instance.
module tb_pcm_playback_pacer;
  import pcm_pkg::*;

  typedef struct packed {
    logic        urun;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en0, en1;
  pcm_frame_t  in_data0;
  logic        in_valid0, in_ready0, strobe0, out_valid0, underrun0;
  logic [31:0] out_data0;
  logic [2:0]  fill0;
  logic [15:0] ucnt0;
  logic [95:0] in_data1, out_data1;
  logic        in_valid1, in_ready1, strobe1, out_valid1, underrun1;
  logic [3:0]  fill1;
  logic [15:0] ucnt1;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pcm_playback_pacer dut0 (
    .ClkIn(clk), .Reset_n(rst_n), .Enable(en0), .In_Data(in_data0),
    .In_Valid(in_valid0), .In_Ready(in_ready0), .Frame_Strobe(strobe0),
    .Out_Data(out_data0), .Out_Valid(out_valid0), .Underrun(underrun0),
    .Fill(fill0), .Underrun_Count(ucnt0)
  );

  pcm_playback_pacer #(
    .CHANNELS(4), .SAMPLE_W(24), .DEPTH(8), .FRAME_PERIOD(5)
  ) dut1 (
    .ClkIn(clk), .Reset_n(rst_n), .Enable(en1), .In_Data(in_data1),
    .In_Valid(in_valid1), .In_Ready(in_ready1), .Frame_Strobe(strobe1),
    .Out_Data(out_data1), .Out_Valid(out_valid1), .Underrun(underrun1),
    .Fill(fill1), .Underrun_Count(ucnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard monitor: every output event of dut0 must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (out_valid0 || underrun0)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind", underrun0, e.urun);
        check("sb_data", out_data0, e.data);
      end
    end
  end

  task automatic wait_strobe(input bit sel, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(sel ? strobe1 : strobe0) && n < 200);
    if (!(sel ? strobe1 : strobe0)) check("strobe_timeout", 0, 1);
  endtask

  task automatic push0(input logic [31:0] d, input bit expect_out);
    in_valid0 = 1'b1;
    in_data0  = d;
    if (expect_out) exp_q.push_back('{urun: 1'b0, data: d});
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  initial begin
    int     n;
    time    t_prev;
    logic [15:0]  exp_uc;
    logic [95:0]  f0, f1;
    logic [31:0]  steady [3];

`ifdef PCM_PACER_UNDERRUN_CNT_EN
    exp_uc = 16'd3;
`else
    exp_uc = 16'd0;
`endif
    steady = '{32'h0009_000A, 32'h000B_000C, 32'h000D_000E};
    f0 = 96'h123456_789ABC_DEF012_345678;
    f1 = 96'hFEDCBA_987654_3210FE_DCBA98;

    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_fill", fill0, 0);
    check("rst_in_ready", in_ready0, 1);
    check("rst_strobe", strobe0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_ucnt", ucnt0, 0);
    @(posedge clk); #1;

    // Fill the FIFO with pacing disabled.
    push0(32'h0001_0002, 1'b1);
    push0(32'h0003_0004, 1'b1);
    push0(32'h0005_0006, 1'b1);
    push0(32'h0007_0008, 1'b1);
    check("full_fill", fill0, 4);
    check("full_in_ready", in_ready0, 0);
    push0(32'hDEAD_BEEF, 1'b0);
    check("full_reject_fill", fill0, 4);
    check("full_reject_ready", in_ready0, 0);

    // Enable pacing: first strobe after 32 edges, then pop frees a slot.
    en0 = 1'b1;
    wait_strobe(1'b0, n);
    check("first_strobe_lat", n, 32);
    t_prev = $time;
    @(posedge clk); #1;
    check("pop_fill", fill0, 3);
    check("pop_in_ready", in_ready0, 1);
    check("pop_out_valid", out_valid0, 1);

    for (int i = 0; i < 3; i++) begin
      push0(steady[i], 1'b1);
      wait_strobe(1'b0, n);
      check("strobe_period", ($time - t_prev) / 10, 32);
      t_prev = $time;
      @(posedge clk); #1;
      check("steady_no_urun", underrun0, 0);
      check("steady_out_valid", out_valid0, 1);
    end

    // Asynchronous reset mid-frame.
    @(posedge clk); #3;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("mrst_fill", fill0, 0);
    check("mrst_in_ready", in_ready0, 1);
    check("mrst_strobe", strobe0, 0);
    check("mrst_out_data", out_data0, 0);
    check("mrst_out_valid", out_valid0, 0);
    check("mrst_underrun", underrun0, 0);
    check("mrst_ucnt", ucnt0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty FIFO with pacing running: each strobe underruns and Out_Data holds 0.
    for (int i = 0; i < 3; i++) exp_q.push_back('{urun: 1'b1, data: 32'h0});
    for (int i = 0; i < 3; i++) begin
      wait_strobe(1'b0, n);
      if (i == 0) check("rst_strobe_lat", n, 32);
      @(posedge clk); #1;
      check("urun_pulse", underrun0, 1);
      check("urun_out_valid", out_valid0, 0);
    end
    check("urun_count", ucnt0, exp_uc);
    check("urun_fill", fill0, 0);

    // Push in the strobe cycle on an empty FIFO.
    exp_q.push_back('{urun: 1'b1, data: 32'h0});
    exp_q.push_back('{urun: 1'b0, data: 32'hAAAA_5555});
    wait_strobe(1'b0, n);
    in_valid0 = 1'b1;
    in_data0  = 32'hAAAA_5555;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    check("simul_urun", underrun0, 1);
    check("simul_fill", fill0, 1);
    wait_strobe(1'b0, n);
    @(posedge clk); #1;
    check("simul_out_data", out_data0, 32'hAAAA_5555);
    check("simul_fill_after", fill0, 0);
    en0 = 1'b0;

    // Parameter sweep instance.
    in_valid1 = 1'b1;
    in_data1  = f0;
    @(posedge clk); #1;
    in_data1  = f1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("p_fill", fill1, 2);
    en1 = 1'b1;
    wait_strobe(1'b1, n);
    check("p_first_lat", n, 5);
    t_prev = $time;
    @(posedge clk); #1;
    check("p_out_valid", out_valid1, 1);
    check("p_out_data0", out_data1, f0);
    wait_strobe(1'b1, n);
    check("p_period", ($time - t_prev) / 10, 5);
    @(posedge clk); #1;
    check("p_out_data1", out_data1, f1);
    wait_strobe(1'b1, n);
    @(posedge clk); #1;
    check("p_urun", underrun1, 1);
    check("p_urun_hold", out_data1, f1);
    en1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
